// File: rtl/dino_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dino_pkg
// Description : Shared definitions for the input arbitration slice: owner
//               mode encodings, the arbiter state type and default tick
//               constants (60 Hz game ticks).
// Revision    : 1.0 - initial release
// ============================================================================
package dino_pkg;

   // Owner encodings as seen on input_arbiter.mode
   localparam logic [1:0] MODE_ATTRACT  = 2'd0;
   localparam logic [1:0] MODE_HANDOVER = 2'd1;
   localparam logic [1:0] MODE_PAD      = 2'd2;
   localparam logic [1:0] MODE_PIN      = 2'd3;

   // 10 s of inactivity at 60 Hz, and the minimum handover dwell
   localparam int DEFAULT_IDLE_TIMEOUT_TICKS = 600;
   localparam int DEFAULT_HANDOVER_TICKS     = 3;

   // State values equal the mode encodings so the state register can drive
   // the mode port directly.
   typedef enum logic [1:0] {
      ST_ATTRACT  = MODE_ATTRACT,
      ST_HANDOVER = MODE_HANDOVER,
      ST_PAD      = MODE_PAD,
      ST_PIN      = MODE_PIN
   } arb_state_t;

endpackage : dino_pkg
`default_nettype wire

// File: rtl/sat_tick_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_tick_counter
// Description : Counts tick pulses up to LIMIT and then holds (never wraps).
//               A clear in the same cycle as a tick wins.
// Ports       : clk   - system clock
//               rst   - asynchronous active-high reset
//               clear - synchronous clear to zero
//               tick  - count enable pulse
//               done  - high while the count equals LIMIT
// Revision    : 1.0 - initial release
// ============================================================================
module sat_tick_counter #(
   parameter int LIMIT = 3,
   parameter int WIDTH = $clog2(LIMIT + 1)
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic tick,
   output logic done
);

   localparam logic [WIDTH-1:0] C_LIMIT = WIDTH'(LIMIT);
   localparam logic [WIDTH-1:0] C_ONE   = WIDTH'(1);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= '0;
      end else if (tick && (r_count != C_LIMIT)) begin
         r_count <= r_count + C_ONE;
      end
   end

   assign done = (r_count == C_LIMIT);

endmodule : sat_tick_counter
`default_nettype wire

// File: rtl/input_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : input_arbiter
// Description : Selects which requester (AI autopilot, SNES gamepad, raw
//               pins) drives player_controller's up/down buttons. Human
//               presses take over from the AI through a handover interval
//               with outputs forced low; inactivity while the game is frozen
//               returns control to the AI.
// Ports       : clk, rst                 - clock, async active-high reset
//               game_tick                - one-cycle 60 Hz pulse
//               game_frozen              - game idle / game over
//               gamepad_present/up/down/start - gamepad levels
//               pin_up, pin_down         - debounced pin levels
//               ai_up                    - AI jump request
//               button_up, button_down   - arbitrated buttons (registered)
//               mode                     - current owner encoding
//               ai_active                - high in attract mode only
// Revision    : 1.0 - initial release
// ============================================================================
module input_arbiter
   import dino_pkg::*;
#(
   parameter int IDLE_TIMEOUT_TICKS = DEFAULT_IDLE_TIMEOUT_TICKS,
   parameter int HANDOVER_TICKS     = DEFAULT_HANDOVER_TICKS
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       game_tick,
   input  logic       game_frozen,
   input  logic       gamepad_present,
   input  logic       gamepad_up,
   input  logic       gamepad_down,
   input  logic       gamepad_start,
   input  logic       pin_up,
   input  logic       pin_down,
   input  logic       ai_up,
   output logic       button_up,
   output logic       button_down,
   output logic [1:0] mode,
   output logic       ai_active
);

   localparam int C_IDLE_W = $clog2(IDLE_TIMEOUT_TICKS + 1);
   localparam int C_HO_W   = $clog2(HANDOVER_TICKS + 1);

   arb_state_t r_state, w_state_next;
   arb_state_t r_target, w_target_next;

   logic r_pad_any_q, r_pin_any_q, r_present_q;
   logic r_armed;
   logic r_button_up, r_button_down, r_ai_active;
   logic w_up_next, w_down_next;

   logic w_pad_any, w_pin_any;
   logic w_pad_press, w_pin_press, w_unplug;
   logic w_ho_clear, w_ho_done;
   logic w_in_play, w_idle_clear, w_idle_tick, w_idle_done;

   assign w_pad_any = gamepad_present & (gamepad_up | gamepad_down | gamepad_start);
   assign w_pin_any = pin_up | pin_down;

   // r_armed stays low for the first clock after reset so that a button held
   // through reset is loaded into the edge registers without being seen as
   // a fresh press.
   assign w_pad_press = r_armed & w_pad_any & ~r_pad_any_q;
   assign w_pin_press = r_armed & w_pin_any & ~r_pin_any_q;
   assign w_unplug    = r_present_q & ~gamepad_present;

   // Handover counter is held at zero outside HANDOVER, so every entry
   // starts from a fresh count.
   assign w_ho_clear = (r_state != ST_HANDOVER);

   sat_tick_counter #(
      .LIMIT (HANDOVER_TICKS),
      .WIDTH (C_HO_W)
   ) u_handover_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (w_ho_clear),
      .tick  (game_tick),
      .done  (w_ho_done)
   );

   // Idle counter: held at zero outside PAD/PIN; human activity on the
   // owning source clears it and takes priority over a tick.
   assign w_in_play    = (r_state == ST_PAD) || (r_state == ST_PIN);
   assign w_idle_clear = ~w_in_play
                       | ((r_state == ST_PAD) & w_pad_any)
                       | ((r_state == ST_PIN) & w_pin_any);
   assign w_idle_tick  = game_tick & game_frozen;

   sat_tick_counter #(
      .LIMIT (IDLE_TIMEOUT_TICKS),
      .WIDTH (C_IDLE_W)
   ) u_idle_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (w_idle_clear),
      .tick  (w_idle_tick),
      .done  (w_idle_done)
   );

   // Edge-detect registers and the post-reset arm flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pad_any_q <= 1'b0;
         r_pin_any_q <= 1'b0;
         r_present_q <= 1'b0;
         r_armed     <= 1'b0;
      end else begin
         r_pad_any_q <= w_pad_any;
         r_pin_any_q <= w_pin_any;
         r_present_q <= gamepad_present;
         r_armed     <= 1'b1;
      end
   end

   // State, target and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= ST_ATTRACT;
         r_target      <= ST_PIN;
         r_button_up   <= 1'b0;
         r_button_down <= 1'b0;
         r_ai_active   <= 1'b1;
      end else begin
         r_state       <= w_state_next;
         r_target      <= w_target_next;
         r_button_up   <= w_up_next;
         r_button_down <= w_down_next;
         r_ai_active   <= (w_state_next == ST_ATTRACT);
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_target_next = r_target;

      case (r_state)
         ST_ATTRACT: begin
            if (w_pad_press || w_pin_press) begin
               w_state_next  = ST_HANDOVER;
               w_target_next = w_pad_press ? ST_PAD : ST_PIN;
            end
         end
         ST_HANDOVER: begin
            if (w_ho_done && !w_pad_any && !w_pin_any) begin
               w_state_next = r_target;
            end
         end
         ST_PAD: begin
            // Unplug beats timeout; held pad input blocks the timeout.
            if (w_unplug) begin
               w_state_next  = ST_HANDOVER;
               w_target_next = ST_PIN;
            end else if (w_idle_done && !w_pad_any) begin
               w_state_next = ST_ATTRACT;
            end
         end
         ST_PIN: begin
            if (w_pad_press) begin
               w_state_next  = ST_HANDOVER;
               w_target_next = ST_PAD;
            end else if (w_idle_done && !w_pin_any) begin
               w_state_next = ST_ATTRACT;
            end
         end
         default: begin
            w_state_next = ST_ATTRACT;
         end
      endcase
   end

   // Buttons are sourced according to the owner being entered, so the
   // registered buttons are always consistent with the registered mode.
   always_comb begin
      w_up_next   = 1'b0;
      w_down_next = 1'b0;

      case (w_state_next)
         ST_ATTRACT: begin
            w_up_next = ai_up;
         end
         ST_PAD: begin
            w_up_next   = gamepad_up | gamepad_start;
            w_down_next = gamepad_down;
         end
         ST_PIN: begin
            w_up_next   = pin_up;
            w_down_next = pin_down;
         end
         default: begin
            w_up_next   = 1'b0;
            w_down_next = 1'b0;
         end
      endcase
   end

   assign button_up   = r_button_up;
   assign button_down = r_button_down;
   assign mode        = r_state;
   assign ai_active   = r_ai_active;

endmodule : input_arbiter
`default_nettype wire

// File: doc/input_arbiter.md
Name: input_arbiter

Overview:
Arbitrates the player_controller's button_up/button_down between three requesters: the AI autopilot (attract mode), the SNES gamepad Pmod, and the raw debounced pins.
Human input takes control from the AI. A handover interval suppresses stray jumps. Control returns to the AI after a period of inactivity while the game is frozen.
Sits between gamepad_pmod_single/ai_controller/pin debouncers and player_controller; clocked by the 60 Hz game tick.

Parameters:
IDLE_TIMEOUT_TICKS, 600, game ticks of no human input (with game_frozen=1) before returning to attract mode (10 s at 60 Hz)
HANDOVER_TICKS, 3, minimum game ticks spent in HANDOVER with all outputs forced low

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
game_tick  input  1  one-cycle 60 Hz pulse from graphics_top
game_frozen  input  1  player_controller idle/game-over indicator
gamepad_present  input  1  gamepad Pmod detected
gamepad_up  input  1  gamepad up (level)
gamepad_down  input  1  gamepad down (level)
gamepad_start  input  1  gamepad start (level)
pin_up  input  1  debounced pin up (level)
pin_down  input  1  debounced pin down (level)
ai_up  input  1  AI controller jump request (level)
button_up  output  1  arbitrated up to player_controller
button_down  output  1  arbitrated down to player_controller
mode  output  2  current owner: 0 ATTRACT, 1 HANDOVER, 2 PAD, 3 PIN
ai_active  output  1  high in ATTRACT only

Behaviour:
- Reset (asynchronous, rst=1): state ATTRACT, target=PIN, handover and idle counters 0, edge registers 0, button_up=0, button_down=0, mode=0, ai_active=1.
- Qualified inputs:
  - pad_any = gamepad_present & (gamepad_up|gamepad_down|gamepad_start).
  - pin_any = pin_up|pin_down.
  - Press events are rising edges of pad_any/pin_any against registered copies.
- Outputs are registered, one-cycle latency from the selected source:
  - ATTRACT: up=ai_up, down=0.
  - HANDOVER: both 0.
  - PAD: up=gamepad_up|gamepad_start, down=gamepad_down.
  - PIN: up=pin_up, down=pin_down.
  - mode/ai_active are registered with state.
- States:
  - ATTRACT → HANDOVER on any press event. Target=PAD if the pad event occurs (wins on a simultaneous pad+pin event), else PIN. Handover counter cleared.
  - HANDOVER:
    - Counter increments on game_tick and saturates at HANDOVER_TICKS.
    - → target state when counter==HANDOVER_TICKS and pad_any=0 and pin_any=0. Idle counter cleared on entry.
    - A press during HANDOVER does not reset the counter; leaving still requires release of all human inputs.
  - PAD:
    - gamepad_present falling → HANDOVER, target PIN.
    - Pin events are ignored.
    - Idle counter: clears on pad_any; else +1 per game_tick while game_frozen=1; holds while game_frozen=0.
    - Counter reaching IDLE_TIMEOUT_TICKS → ATTRACT.
  - PIN:
    - Pad press event (gamepad_present=1) → HANDOVER, target PAD.
    - Idle counter as in PAD, but cleared by pin_any.
    - Timeout → ATTRACT.
- Simultaneous events:
  - Human-input clear beats a game_tick increment in the same cycle.
  - Timeout and a press in the same cycle: the press wins (stay, counter cleared).
  - In PAD, gamepad unplug beats timeout.
- Widths: idle counter $clog2(IDLE_TIMEOUT_TICKS+1) bits, handover counter $clog2(HANDOVER_TICKS+1) bits; both saturate and never wrap.
- Reset mid-play: immediate return to ATTRACT with outputs low.
- A held button at reset does not create a press event in the first cycle after reset, because the edge registers reset to 0 and are loaded on the first clock; pressing must occur after that.

Decomposition:
- Shared package dino_pkg: mode encodings (MODE_ATTRACT=2'd0, MODE_HANDOVER=2'd1, MODE_PAD=2'd2, MODE_PIN=2'd3) and the default tick constants.
- One natural sub-module, sat_tick_counter: parameterised width/limit, inputs clear, tick, output done. Instantiated twice (handover, idle).

Test Plan:
1. Reset, ai_up pulses → button_up follows ai_up with 1-cycle latency; mode=0, ai_active=1.
2. From ATTRACT, pin_up held 1 for 2 ticks then released → mode=1 with outputs 0 for ≥3 game_ticks; then mode=3; next pin_up press gives button_up=1 one cycle later; ai_up ignored.
3. gamepad_present=1, pin_up and gamepad_up rise in the same cycle → target PAD; after release and 3 ticks mode=2; pin_down=1 produces button_down=0; gamepad_down produces button_down=1.
4. In PAD, drop gamepad_present → mode=1 then mode=3 after 3 ticks with inputs released.
5. In PIN with game_frozen=1 and no input for 600 ticks → mode=0 on tick 600. Repeat with game_frozen=0 → no timeout. Repeat with a pin press at tick 599 → stays in PIN, counter 0.
6. Assert rst mid-HANDOVER → asynchronously mode=0, outputs 0; held pin_up at release of rst causes no handover.
